// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends one byte on the device clock,
// and reports ACK / no-ACK / timeout. Pins are driven open-drain via the *_oe outputs.
//  state     | meaning
//  IDLE      | bus released, ready for a byte
//  INHIBIT   | clock held low to preempt any device transfer
//  START     | clock and data both low (start bit)
//  DATA      | 8 data bits driven on device clock falls
//  PARITY    | odd parity driven on next fall
//  STOP      | data released (stop bit) on next fall
//  ACK       | device ACK sampled on next fall
//  WAIT_IDLE | wait for both lines high
//  FINISH    | done pulse with status
module ps2_host_tx #(
  parameter int CLK_HZ     = 25000000,
  parameter int INHIBIT_US = 100,
  parameter int START_HOLD = 25,
  parameter int TIMEOUT_MS = 15,
  parameter int FILTER_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic [1:0] status,
  output logic       busy
);
  localparam int INH_CYC = CLK_HZ / 1000000 * INHIBIT_US;
  localparam int TO_CYC  = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int TMR_MAX = (INH_CYC > START_HOLD) ? INH_CYC : START_HOLD;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int TO_W    = $clog2(TO_CYC + 1);
  localparam int FLT_W   = $clog2(FILTER_LEN + 1);

  localparam logic [TMR_W-1:0] INH_LOAD   = TMR_W'(INH_CYC - 1);
  localparam logic [TMR_W-1:0] START_LOAD = TMR_W'(START_HOLD - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TO_CYC - 1);
  localparam logic [FLT_W-1:0] FLT_LAST   = FLT_W'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK, WAIT_IDLE, FINISH
  } state_t;

  state_t           state, state_n;
  logic [1:0]       clk_sync, data_sync;
  logic             clk_s, data_s;
  logic [FLT_W-1:0] flt_cnt;
  logic             clk_f, fall;
  logic [TMR_W-1:0] tmr, tmr_n;
  logic [TO_W-1:0]  to_cnt, to_cnt_n;
  logic [7:0]       sh, sh_n;
  logic             par, par_n;
  logic [3:0]       bitcnt, bitcnt_n;
  logic             data_oe_q, data_oe_n;
  logic [1:0]       res, res_n;
  logic             to_run, expired;

  // Synchronizers reset to the idle (released) bus level so reset never makes a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_cnt <= '0;
      clk_f   <= 1'b1;
      fall    <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        flt_cnt <= '0;
        clk_f   <= clk_s;
        fall    <= ~clk_s;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign to_run  = state inside {DATA, PARITY, STOP, ACK, WAIT_IDLE};
  assign expired = to_run && (to_cnt == TO_LAST);

  always_comb begin
    state_n   = state;
    tmr_n     = tmr;
    to_cnt_n  = to_cnt;
    sh_n      = sh;
    par_n     = par;
    bitcnt_n  = bitcnt;
    data_oe_n = data_oe_q;
    res_n     = res;
    if (to_run) to_cnt_n = fall ? '0 : to_cnt + 1'b1;
    unique case (state)
      IDLE: if (tx_valid) begin
        sh_n     = tx_data;
        par_n    = ~^tx_data;
        bitcnt_n = '0;
        tmr_n    = INH_LOAD;
        state_n  = INHIBIT;
      end
      INHIBIT: if (tmr == '0) begin
        tmr_n     = START_LOAD;
        data_oe_n = 1'b1;
        state_n   = START;
      end else begin
        tmr_n = tmr - 1'b1;
      end
      START: if (tmr == '0) begin
        to_cnt_n = '0;
        state_n  = DATA;
      end else begin
        tmr_n = tmr - 1'b1;
      end
      DATA: if (fall) begin
        data_oe_n = ~sh[0];
        sh_n      = {1'b0, sh[7:1]};
        bitcnt_n  = bitcnt + 1'b1;
        if (bitcnt == 4'd7) state_n = PARITY;
      end
      PARITY: if (fall) begin
        data_oe_n = ~par;
        state_n   = STOP;
      end
      STOP: if (fall) begin
        data_oe_n = 1'b0;
        state_n   = ACK;
      end
      ACK: if (fall) begin
        res_n   = data_s ? 2'b01 : 2'b00;
        state_n = WAIT_IDLE;
      end
      WAIT_IDLE: if (clk_f && data_s) state_n = FINISH;
      FINISH:    state_n = IDLE;
      default:   state_n = IDLE;
    endcase
    // Expiry wins over a coincident fall.
    if (expired) begin
      data_oe_n = 1'b0;
      res_n     = 2'b10;
      state_n   = FINISH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmr       <= '0;
      to_cnt    <= '0;
      sh        <= '0;
      par       <= 1'b0;
      bitcnt    <= '0;
      data_oe_q <= 1'b0;
      res       <= 2'b00;
    end else begin
      state     <= state_n;
      tmr       <= tmr_n;
      to_cnt    <= to_cnt_n;
      sh        <= sh_n;
      par       <= par_n;
      bitcnt    <= bitcnt_n;
      data_oe_q <= data_oe_n;
      res       <= res_n;
    end
  end

  assign ps2_clk_oe  = (state == INHIBIT) || (state == START);
  assign ps2_data_oe = data_oe_q;
  assign done        = (state == FINISH);
  assign status      = res;
  assign tx_ready    = (state == IDLE);
  assign busy        = ~tx_ready;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host; sampled bits
// and completion status are checked against scoreboard queues filled when each byte is sent.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int HALF = 750;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, done, busy;
  logic [1:0] status;
  logic       dev_clk = 1'b1, dev_data = 1'b1, glitch = 1'b0;
  logic       ps2_clk_i, ps2_data_i;
  int         checks = 0, failures = 0;
  logic       bit_q[$];
  logic [1:0] status_q[$];

  // Wired-AND bus: pull-ups high, host or device may pull low.
  assign ps2_clk_i  = dev_clk & ~ps2_clk_oe & ~glitch;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.TIMEOUT_MS(1)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .done(done), .status(status), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample_bit(input string tag);
    logic e;
    e = (bit_q.size() > 0) ? bit_q.pop_front() : 1'bx;
    check(tag, 32'(ps2_data_i), 32'(e));
  endtask

  // Request a byte, optionally poke a second request while busy, and time the clock inhibit.
  task automatic start_tx(input logic [7:0] d, input logic [1:0] st, input bit push_bits,
                          input bit poke);
    int n;
    check("ready_before", 32'(tx_ready), 1);
    if (push_bits) begin
      bit_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) bit_q.push_back(d[i]);
      bit_q.push_back(~^d);
      bit_q.push_back(1'b1);
    end
    status_q.push_back(st);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 1);
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < 5000) begin
      if (poke && n == 100) begin
        tx_data  = 8'h55;
        tx_valid = 1'b1;
      end
      if (poke && n == 101) begin
        tx_valid = 1'b0;
        check("ready_low_while_busy", 32'(tx_ready), 0);
      end
      n++;
      @(negedge clk);
    end
    check("clk_low_cycles", 32'(n), 2525);
  endtask

  // Device clock pulses; each rising edge samples the data line.
  task automatic dev_bits(input int npulse, input int glitch_pulse);
    for (int i = 0; i < npulse; i++) begin
      if (i == glitch_pulse) begin
        repeat (300) @(negedge clk);
        glitch = 1'b1;
        repeat (3) @(negedge clk);
        glitch = 1'b0;
        repeat (HALF - 303) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      sample_bit($sformatf("bit%0d", i + 1));
    end
  endtask

  task automatic ack_slot(input bit ack);
    repeat (HALF / 2) @(negedge clk);
    dev_data = ~ack;
    repeat (HALF - HALF / 2) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
  endtask

  task automatic wait_done(input int limit, output int n);
    logic [1:0] est;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    est = (status_q.size() > 0) ? status_q.pop_front() : 2'bxx;
    check("done_seen", 32'(done), 1);
    check("status", 32'(status), 32'(est));
    check("clk_oe_released", 32'(ps2_clk_oe), 0);
    check("data_oe_released", 32'(ps2_data_oe), 0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("ready_after_done", 32'(tx_ready), 1);
  endtask

  initial begin
    int n;
    int done_cnt;
    repeat (5) @(negedge clk);
    check("rst_clk_oe", 32'(ps2_clk_oe), 0);
    check("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(tx_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_data_oe", 32'(ps2_data_oe), 0);
    check("rst_status", 32'(status), 0);

    // ACKed frame with a busy-time request and a clock glitch during data
    start_tx(8'hED, 2'b00, 1'b1, 1'b1);
    sample_bit("start");
    dev_bits(10, 3);
    ack_slot(1'b1);
    wait_done(200, n);
    check("bits_consumed", 32'(bit_q.size()), 0);
    repeat (50) @(negedge clk);

    // No ACK from the device
    start_tx(8'hED, 2'b01, 1'b1, 1'b0);
    sample_bit("start");
    dev_bits(10, -1);
    ack_slot(1'b0);
    wait_done(200, n);
    repeat (50) @(negedge clk);

    // Device never clocks: timeout measured from clock release
    start_tx(8'hED, 2'b10, 1'b0, 1'b0);
    wait_done(30000, n);
    check("timeout_cycles", 32'(n), 25000);
    repeat (50) @(negedge clk);

    // Reset after data bit 4 (a 0, so data is being pulled low)
    start_tx(8'hED, 2'b00, 1'b1, 1'b0);
    sample_bit("start");
    dev_bits(5, -1);
    repeat (100) @(negedge clk);
    check("data_oe_before_rst", 32'(ps2_data_oe), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_clk_oe", 32'(ps2_clk_oe), 0);
    check("rst_async_data_oe", 32'(ps2_data_oe), 0);
    bit_q.delete();
    status_q.delete();
    done_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(tx_ready), 1);
    repeat (30) begin
      if (done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    check("no_done_after_rst", 32'(done_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
